// File: rtl/mem_access_ctrl.sv
// MEM-stage data memory access controller: drives a registered request/ack
// memory port with timeout, and produces pipeline stall/bubble controls.
module mem_access_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_DM_read,
    input  logic        mem_DM_write,
    input  logic [31:0] mem_alu_result,
    input  logic [31:0] mem_sw_o,
    input  logic        exe_DM_read,
    input  logic [4:0]  exe_write_addr_o,
    input  logic [4:0]  id_rs1_addr,
    input  logic [4:0]  id_rs2_addr,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic        mem_stall,
    output logic        id_stall,
    output logic        exe_bubble,
    output logic [31:0] ld_data,
    output logic        dm_err,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] ld_q, ld_d;
    logic        err_q, err_d;

    logic access;
    logic timeout_hit;
    logic load_use;
    logic mem_stall_c;

    assign access      = mem_DM_read | mem_DM_write;
    assign timeout_hit = (cnt_q == TIMEOUT_C);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // An ack always wins over a coincident timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (access) state_d = WAIT;
            WAIT:    if (dm_ack || timeout_hit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ld_d    = ld_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (access) begin
                    req_d   = 1'b1;
                    we_d    = mem_DM_write;
                    addr_d  = mem_alu_result;
                    wdata_d = mem_sw_o;
                    cnt_d   = 8'd0;
                end
            end
            WAIT: begin
                if (dm_ack) begin
                    req_d = 1'b0;
                    if (!we_q) ld_d = dm_rdata;
                end else if (timeout_hit) begin
                    req_d = 1'b0;
                    err_d = 1'b1;
                    if (!we_q) ld_d = 32'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= 8'd0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            ld_q    <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ld_q    <= ld_d;
            err_q   <= err_d;
        end
    end

    // A memory stall freezes the whole pipeline, so it suppresses the bubble.
    assign mem_stall_c = ~rst & (((state_q == IDLE) & access) | (state_q == WAIT));
    assign load_use    = exe_DM_read & (exe_write_addr_o != 5'd0) &
                         ((exe_write_addr_o == id_rs1_addr) | (exe_write_addr_o == id_rs2_addr));

    assign mem_stall   = mem_stall_c;
    assign id_stall    = ~rst & load_use & ~mem_stall_c;
    assign exe_bubble  = ~rst & load_use & ~mem_stall_c;
    assign dm_req      = req_q;
    assign dm_we       = we_q;
    assign dm_addr     = addr_q;
    assign dm_wdata    = wdata_q;
    assign ld_data     = ld_q;
    assign dm_err      = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with TIMEOUT=4: loads, stores, timeout,
// ack/timeout tie, load-use hazards and reset abort.
module tb_mem_access_ctrl;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic        clk;
    logic        rst;
    logic        mem_DM_read;
    logic        mem_DM_write;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_sw_o;
    logic        exe_DM_read;
    logic [4:0]  exe_write_addr_o;
    logic [4:0]  id_rs1_addr;
    logic [4:0]  id_rs2_addr;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        mem_stall;
    logic        id_stall;
    logic        exe_bubble;
    logic [31:0] ld_data;
    logic        dm_err;
    logic [1:0]  dbg_state_o;

    int tests_run;
    int tests_failed;

    mem_access_ctrl #(.TIMEOUT(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .mem_DM_read      (mem_DM_read),
        .mem_DM_write     (mem_DM_write),
        .mem_alu_result   (mem_alu_result),
        .mem_sw_o         (mem_sw_o),
        .exe_DM_read      (exe_DM_read),
        .exe_write_addr_o (exe_write_addr_o),
        .id_rs1_addr      (id_rs1_addr),
        .id_rs2_addr      (id_rs2_addr),
        .dm_ack           (dm_ack),
        .dm_rdata         (dm_rdata),
        .dm_req           (dm_req),
        .dm_we            (dm_we),
        .dm_addr          (dm_addr),
        .dm_wdata         (dm_wdata),
        .mem_stall        (mem_stall),
        .id_stall         (id_stall),
        .exe_bubble       (exe_bubble),
        .ld_data          (ld_data),
        .dm_err           (dm_err),
        .dbg_state_o      (dbg_state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        int n;
        tests_run        = 0;
        tests_failed     = 0;
        rst              = 1'b1;
        mem_DM_read      = 1'b0;
        mem_DM_write     = 1'b0;
        mem_alu_result   = 32'd0;
        mem_sw_o         = 32'd0;
        exe_DM_read      = 1'b0;
        exe_write_addr_o = 5'd0;
        id_rs1_addr      = 5'd0;
        id_rs2_addr      = 5'd0;
        dm_ack           = 1'b0;
        dm_rdata         = 32'd0;
        tick();
        tick();

        // Reset values
        check("rst_req", 32'(dm_req), 32'd0);
        check("rst_we", 32'(dm_we), 32'd0);
        check("rst_addr", dm_addr, 32'd0);
        check("rst_wdata", dm_wdata, 32'd0);
        check("rst_ld", ld_data, 32'd0);
        check("rst_err", 32'(dm_err), 32'd0);
        check("rst_state", 32'(dbg_state_o), 32'(S_IDLE));
        rst = 1'b0;
        settle();

        // Minimum-latency load
        mem_DM_read    = 1'b1;
        mem_alu_result = 32'h100;
        settle();
        check("ld_stall_n", 32'(mem_stall), 32'd1);
        check("ld_req_n", 32'(dm_req), 32'd0);
        tick();
        check("ld_state_n1", 32'(dbg_state_o), 32'(S_WAIT));
        check("ld_req_n1", 32'(dm_req), 32'd1);
        check("ld_we_n1", 32'(dm_we), 32'd0);
        check("ld_addr_n1", dm_addr, 32'h100);
        check("ld_stall_n1", 32'(mem_stall), 32'd1);
        dm_ack   = 1'b1;
        dm_rdata = 32'hDEADBEEF;
        tick();
        dm_ack = 1'b0;
        settle();
        check("ld_state_n2", 32'(dbg_state_o), 32'(S_DONE));
        check("ld_stall_n2", 32'(mem_stall), 32'd0);
        check("ld_req_n2", 32'(dm_req), 32'd0);
        check("ld_data", ld_data, 32'hDEADBEEF);
        check("ld_err", 32'(dm_err), 32'd0);
        mem_DM_read = 1'b0;
        tick();
        check("ld_back_idle", 32'(dbg_state_o), 32'(S_IDLE));

        // Stray ack in IDLE is ignored
        dm_ack   = 1'b1;
        dm_rdata = 32'h0BADF00D;
        tick();
        dm_ack = 1'b0;
        settle();
        check("idle_ack_state", 32'(dbg_state_o), 32'(S_IDLE));
        check("idle_ack_ld", ld_data, 32'hDEADBEEF);
        check("idle_ack_req", 32'(dm_req), 32'd0);

        // Store acked in the fourth WAIT cycle
        mem_DM_write   = 1'b1;
        mem_alu_result = 32'h200;
        mem_sw_o       = 32'h12345678;
        tick();
        mem_alu_result = 32'hFFFF_FFFF;
        mem_sw_o       = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            check("st_req", 32'(dm_req), 32'd1);
            check("st_we", 32'(dm_we), 32'd1);
            check("st_addr", dm_addr, 32'h200);
            check("st_wdata", dm_wdata, 32'h12345678);
            check("st_stall", 32'(mem_stall), 32'd1);
            if (i == 3) begin
                dm_ack   = 1'b1;
                dm_rdata = 32'h55555555;
            end
            tick();
        end
        dm_ack = 1'b0;
        settle();
        check("st_state", 32'(dbg_state_o), 32'(S_DONE));
        check("st_req_off", 32'(dm_req), 32'd0);
        check("st_ld_keep", ld_data, 32'hDEADBEEF);
        check("st_err", 32'(dm_err), 32'd0);
        mem_DM_write = 1'b0;
        tick();

        // Read and write together behave as a write
        mem_DM_read    = 1'b1;
        mem_DM_write   = 1'b1;
        mem_alu_result = 32'h300;
        mem_sw_o       = 32'hA5A5A5A5;
        tick();
        check("rw_we", 32'(dm_we), 32'd1);
        check("rw_wdata", dm_wdata, 32'hA5A5A5A5);
        dm_ack   = 1'b1;
        dm_rdata = 32'h66666666;
        tick();
        dm_ack = 1'b0;
        settle();
        check("rw_ld_keep", ld_data, 32'hDEADBEEF);
        mem_DM_read  = 1'b0;
        mem_DM_write = 1'b0;
        tick();

        // Load timeout with no ack
        mem_DM_read    = 1'b1;
        mem_alu_result = 32'h400;
        tick();
        n = 0;
        while (dm_req && n < 20) begin
            check("to_no_err", 32'(dm_err), 32'd0);
            n++;
            tick();
        end
        check("to_req_cycles", 32'(n), 32'd5);
        check("to_state", 32'(dbg_state_o), 32'(S_DONE));
        check("to_err", 32'(dm_err), 32'd1);
        check("to_ld_zero", ld_data, 32'd0);
        mem_DM_read = 1'b0;
        tick();
        check("to_err_pulse", 32'(dm_err), 32'd0);
        check("to_idle", 32'(dbg_state_o), 32'(S_IDLE));

        // Ack in the same cycle as the timeout
        mem_DM_read    = 1'b1;
        mem_alu_result = 32'h480;
        tick();
        for (int i = 0; i < 4; i++) tick();
        check("tie_state", 32'(dbg_state_o), 32'(S_WAIT));
        dm_ack   = 1'b1;
        dm_rdata = 32'hCAFEF00D;
        tick();
        dm_ack = 1'b0;
        settle();
        check("tie_ld", ld_data, 32'hCAFEF00D);
        check("tie_err", 32'(dm_err), 32'd0);
        mem_DM_read = 1'b0;
        tick();

        // Load-use hazard detection
        exe_DM_read      = 1'b1;
        exe_write_addr_o = 5'd5;
        id_rs1_addr      = 5'd3;
        id_rs2_addr      = 5'd5;
        settle();
        check("lu_rs2_stall", 32'(id_stall), 32'd1);
        check("lu_rs2_bubble", 32'(exe_bubble), 32'd1);
        id_rs1_addr = 5'd5;
        id_rs2_addr = 5'd7;
        settle();
        check("lu_rs1_stall", 32'(id_stall), 32'd1);
        exe_write_addr_o = 5'd0;
        id_rs1_addr      = 5'd0;
        id_rs2_addr      = 5'd0;
        settle();
        check("lu_r0_stall", 32'(id_stall), 32'd0);
        check("lu_r0_bubble", 32'(exe_bubble), 32'd0);
        exe_DM_read      = 1'b0;
        exe_write_addr_o = 5'd5;
        id_rs2_addr      = 5'd5;
        settle();
        check("lu_noload", 32'(id_stall), 32'd0);

        // Hazard alongside a pending MEM load
        exe_DM_read    = 1'b1;
        mem_DM_read    = 1'b1;
        mem_alu_result = 32'h500;
        settle();
        check("cc_mstall_idle", 32'(mem_stall), 32'd1);
        check("cc_idstall_idle", 32'(id_stall), 32'd0);
        check("cc_bubble_idle", 32'(exe_bubble), 32'd0);
        tick();
        check("cc_idstall_wait", 32'(id_stall), 32'd0);
        dm_ack   = 1'b1;
        dm_rdata = 32'h11112222;
        tick();
        dm_ack = 1'b0;
        settle();
        check("cc_mstall_done", 32'(mem_stall), 32'd0);
        check("cc_idstall_done", 32'(id_stall), 32'd1);
        check("cc_bubble_done", 32'(exe_bubble), 32'd1);
        check("cc_ld", ld_data, 32'h11112222);
        mem_DM_read = 1'b0;
        tick();

        // Reset in WAIT aborts the access; late ack is ignored
        mem_DM_read    = 1'b1;
        mem_alu_result = 32'h600;
        tick();
        tick();
        check("ra_state", 32'(dbg_state_o), 32'(S_WAIT));
        rst = 1'b1;
        settle();
        check("ra_mstall_rst", 32'(mem_stall), 32'd0);
        check("ra_idstall_rst", 32'(id_stall), 32'd0);
        check("ra_bubble_rst", 32'(exe_bubble), 32'd0);
        tick();
        rst         = 1'b0;
        mem_DM_read = 1'b0;
        exe_DM_read = 1'b0;
        dm_ack      = 1'b1;
        dm_rdata    = 32'h77777777;
        settle();
        check("ra_req", 32'(dm_req), 32'd0);
        check("ra_ld", ld_data, 32'd0);
        tick();
        dm_ack = 1'b0;
        settle();
        check("ra_state_after", 32'(dbg_state_o), 32'(S_IDLE));
        check("ra_ld_after", ld_data, 32'd0);
        check("ra_err", 32'(dm_err), 32'd0);
        check("ra_req_after", 32'(dm_req), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 255, the maximum number of WAIT cycles allowed without dm_ack (range 1..255).
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 mem_DM_read  input  1  the MEM-stage instruction is a load.
REQ-005 mem_DM_write  input  1  the MEM-stage instruction is a store.
REQ-006 mem_alu_result  input  32  MEM-stage effective address.
REQ-007 mem_sw_o  input  32  MEM-stage store data.
REQ-008 exe_DM_read  input  1  the EXE-stage instruction is a load.
REQ-009 exe_write_addr_o  input  5  EXE-stage destination register.
REQ-010 id_rs1_addr, id_rs2_addr  input  5 each  ID-stage source registers.
REQ-011 dm_ack  input  1  data memory completion, one-cycle pulse.
REQ-012 dm_rdata  input  32  data memory read data, valid when dm_ack=1.
REQ-013 dm_req  output  1  registered memory request.
REQ-014 dm_we  output  1  registered; 1=write, 0=read.
REQ-015 dm_addr, dm_wdata  output  32 each  registered, held stable while dm_req=1.
REQ-016 mem_stall  output  1  freezes the PC and the IF/ID, ID/EXE, EXE/MEM and MEM/WB registers.
REQ-017 id_stall  output  1  holds the PC and IF/ID for a load-use hazard.
REQ-018 exe_bubble  output  1  zeroes the ID/EXE control fields on the next edge.
REQ-019 ld_data  output  32  registered captured load data.
REQ-020 dm_err  output  1  registered one-cycle timeout pulse.

Function
REQ-021 The FSM SHALL have three states: IDLE, WAIT and DONE.
REQ-022 IDLE with (mem_DM_read|mem_DM_write)=1 SHALL move to WAIT and, on the same edge, register dm_req=1, dm_we=mem_DM_write, dm_addr=mem_alu_result and dm_wdata=mem_sw_o.
REQ-023 If mem_DM_read and mem_DM_write are both 1, the access SHALL be treated as a write.
REQ-024 WAIT with dm_ack=1 SHALL move to DONE, clear dm_req, and, for a read, load ld_data<=dm_rdata; a write SHALL leave ld_data unchanged.
REQ-025 WAIT without dm_ack SHALL increment an 8-bit wait counter; that counter SHALL clear on entry to WAIT.
REQ-026 When the counter equals TIMEOUT with dm_ack=0, the FSM SHALL move to DONE, clear dm_req, pulse dm_err=1 for one cycle and, for a read, set ld_data=0.
REQ-027 dm_ack and the timeout occurring in the same cycle SHALL be resolved as an ack, with no dm_err.
REQ-028 DONE SHALL move unconditionally to IDLE, so each MEM-stage instruction is serviced exactly once.
REQ-029 dm_ack received in IDLE or DONE SHALL be ignored.
REQ-030 mem_stall SHALL be combinational: 1 when (IDLE and an access is pending) or in WAIT; 0 in DONE.
REQ-031 Minimum access latency: access seen at cycle N gives dm_req=1 at N+1; dm_ack at N+1 gives DONE at N+2; mem_stall is high for exactly cycles N and N+1.
REQ-032 load_use SHALL be exe_DM_read & (exe_write_addr_o!=0) & (exe_write_addr_o==id_rs1_addr | exe_write_addr_o==id_rs2_addr).
REQ-033 id_stall and exe_bubble SHALL equal load_use & ~mem_stall; mem_stall SHALL take priority and freeze the whole pipeline with no bubble.
REQ-034 Register r0 as the EXE destination SHALL never produce a hazard.

Reset
REQ-035 When rst=1 on a clock edge: state=IDLE, counter=0, dm_req=0, dm_we=0, dm_addr=0, dm_wdata=0, ld_data=0, dm_err=0.
REQ-036 Reset asserted in WAIT or DONE SHALL abort the access: dm_req=0 after that edge and no dm_err.
REQ-037 While rst=1, mem_stall, id_stall and exe_bubble SHALL be driven 0.

Verification
REQ-038 Load, addr=0x100, dm_ack one cycle after dm_req with rdata=0xDEADBEEF -> mem_stall high exactly 2 cycles, ld_data=0xDEADBEEF, dm_we=0.
REQ-039 Store, addr=0x200, data=0x12345678, dm_ack after 3 WAIT cycles -> dm_we=1, dm_addr/dm_wdata stable for 4 cycles, ld_data unchanged.
REQ-040 TIMEOUT=4, load, no dm_ack -> dm_req high 5 cycles, dm_err pulses once, ld_data=0, FSM returns to IDLE.
REQ-041 exe_DM_read=1, exe_write_addr_o=5, id_rs2_addr=5 -> id_stall=1 and exe_bubble=1; the same with exe_write_addr_o=0 -> both 0.
REQ-042 Load-use hazard concurrent with a pending MEM load -> mem_stall=1, id_stall=0, exe_bubble=0 until DONE, then id_stall=1.
REQ-043 rst pulsed in WAIT, followed by a late dm_ack -> dm_req=0, ld_data=0, no dm_err, FSM stays in IDLE.
